// File: rtl/systema_btn_debounce.sv
// Per-channel push-button conditioner: polarity normalise, two-flop synchroniser,
// and a stability-counter FSM that yields a clean level plus press/release strobes.
module systema_btn_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    REL,
    WAIT_P,
    PRS,
    WAIT_R
  } state_t;

  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // Normalised so that 1 always means "pressed" from here on.
  assign norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= norm;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      state_t        state_reg;
      state_t        state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          btn_reg;
      logic          btn_next;
      logic          press_reg;
      logic          press_next;
      logic          release_reg;
      logic          release_next;
      logic          s;

      assign s = sync2_reg[gi];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state_reg   <= REL;
          cnt_reg     <= '0;
          btn_reg     <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          btn_reg     <= btn_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      // The count includes the sample that opened the window, so the wait
      // states start at 1 and accept on the DEBOUNCE_CYCLES-th agreeing sample.
      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        btn_next     = btn_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
          REL: begin
            if (s) begin
              state_next = WAIT_P;
              cnt_next   = ONE;
            end else begin
              cnt_next = '0;
            end
          end
          WAIT_P: begin
            if (!s) begin
              state_next = REL;
              cnt_next   = '0;
            end else if (cnt_reg == TERM) begin
              state_next = PRS;
              btn_next   = 1'b1;
              press_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + ONE;
            end
          end
          PRS: begin
            if (!s) begin
              state_next = WAIT_R;
              cnt_next   = ONE;
            end else begin
              cnt_next = '0;
            end
          end
          WAIT_R: begin
            if (s) begin
              state_next = PRS;
              cnt_next   = '0;
            end else if (cnt_reg == TERM) begin
              state_next   = REL;
              btn_next     = 1'b0;
              release_next = 1'b1;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + ONE;
            end
          end
          default: begin
            state_next = REL;
            cnt_next   = '0;
            btn_next   = 1'b0;
          end
        endcase
      end

      assign btn_out[gi]       = btn_reg;
      assign press_pulse[gi]   = press_reg;
      assign release_pulse[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_systema_btn_debounce.sv
// Bench for systema_btn_debounce: vector table, hand-written corner sequences,
// and randomised stimulus against a run-length reference model.
module tb_systema_btn_debounce;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int press_cnt [2];
  int rel_cnt [2];
  int first_press [2];
  int both_press;
  int rel_10;

  systema_btn_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_out(btn_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Reference: a level flips once DC consecutive synchronised samples disagree with it.
  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] btn;
    logic [1:0] press;
    logic [1:0] rel;
    int         run0;
    int         run1;
  } mstate_t;

  function automatic mstate_t model_step(mstate_t m, logic rst, logic [1:0] raw);
    mstate_t n;
    int      run [2];
    n = m;
    if (!rst) begin
      n = '0;
      return n;
    end
    run[0]  = m.run0;
    run[1]  = m.run1;
    n.press = '0;
    n.rel   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (m.s2[ch] != m.btn[ch]) begin
        run[ch] = run[ch] + 1;
        if (run[ch] == DC) begin
          n.btn[ch]   = m.s2[ch];
          n.press[ch] = m.s2[ch];
          n.rel[ch]   = ~m.s2[ch];
          run[ch]     = 0;
        end
      end else begin
        run[ch] = 0;
      end
    end
    n.run0 = run[0];
    n.run1 = run[1];
    n.s2   = m.s1;
    n.s1   = ~raw;
    return n;
  endfunction

  mstate_t m = '0;

  always @(posedge clk) m <= model_step(m, reset_n, btn_raw);

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] out;
    logic [1:0] pr;
    logic [1:0] rl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [1:0] raw, input logic [1:0] out,
                     input logic [1:0] pr, input logic [1:0] rl, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.out = out; v.pr = pr; v.rl = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic clr();
    for (int ch = 0; ch < 2; ch++) begin
      press_cnt[ch]   = 0;
      rel_cnt[ch]     = 0;
      first_press[ch] = -1;
    end
    both_press = 0;
    rel_10     = 0;
  endtask

  task automatic cyc(input logic rst, input logic [1:0] raw);
    reset_n = rst;
    btn_raw = raw;
    @(posedge clk);
    #1;
    cyc_n++;
    n_tests++;
    if ({btn_out, press_pulse, release_pulse} !== {m.btn, m.press, m.rel}) begin
      n_fail++;
      $display("FAIL model cyc=%0d out=%b want %b press=%b want %b rel=%b want %b",
               cyc_n, btn_out, m.btn, press_pulse, m.press, release_pulse, m.rel);
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (press_pulse[ch] === 1'b1) begin
        press_cnt[ch]++;
        if (first_press[ch] < 0) first_press[ch] = cyc_n;
      end
      if (release_pulse[ch] === 1'b1) rel_cnt[ch]++;
    end
    if (press_pulse === 2'b11) both_press++;
    if (release_pulse === 2'b10) rel_10++;
  endtask

  task automatic hold(input logic rst, input logic [1:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(rst, raw);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, act);
    end
  endtask

  initial begin
    int t_mark;
    int done;

    // Reset with both held, then press acceptance 5 edges after the first sampling edge.
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    add(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1);
    // Release both.
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 1);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    // Clean press then release on channel 0.
    add(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b10, 2'b01, 2'b01, 2'b00, 1);
    add(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1);
    add(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 1);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1);

    clr();
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].raw);
      n_tests++;
      if ({btn_out, press_pulse, release_pulse} !== {vecs[i].out, vecs[i].pr, vecs[i].rl}) begin
        n_fail++;
        $display("FAIL vec%0d got out=%b pr=%b rl=%b expected out=%b pr=%b rl=%b",
                 i, btn_out, press_pulse, release_pulse, vecs[i].out, vecs[i].pr, vecs[i].rl);
      end else begin
        $display("[TB] vec%0d rst=%b raw=%b out=%b pr=%b rl=%b", i, vecs[i].rst,
                 vecs[i].raw, btn_out, press_pulse, release_pulse);
      end
    end

    // Bounce every 2 cycles, ending released: nothing accepted.
    clr();
    for (int j = 0; j < 10; j++) hold(1'b1, {1'b1, j[0]}, 2);
    hold(1'b1, 2'b11, 10);
    check("bounce_rel_press0", press_cnt[0], 0);
    check("bounce_rel_release0", rel_cnt[0], 0);
    check("bounce_rel_out0", int'(btn_out[0]), 0);

    // Bounce ending pressed: one press, 5 edges after the last transition.
    clr();
    t_mark = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 9) t_mark = cyc_n + 1;
      hold(1'b1, {1'b1, ~j[0]}, 2);
    end
    hold(1'b1, 2'b10, 8);
    check("bounce_prs_count0", press_cnt[0], 1);
    check("bounce_prs_latency0", first_press[0] - t_mark, 5);
    hold(1'b1, 2'b11, 10);
    check("bounce_prs_release0", rel_cnt[0], 1);

    // Near-miss glitches on channel 1.
    clr();
    hold(1'b1, 2'b01, 3);
    hold(1'b1, 2'b11, 10);
    check("glitch3_press1", press_cnt[1], 0);
    check("glitch3_out1", int'(btn_out[1]), 0);
    clr();
    hold(1'b1, 2'b01, 4);
    hold(1'b1, 2'b11, 12);
    check("glitch4_press1", press_cnt[1], 1);
    check("glitch4_release1", rel_cnt[1], 1);

    // Simultaneous press, then release of channel 1 only.
    clr();
    hold(1'b1, 2'b00, 8);
    check("simul_both_press", both_press, 1);
    check("simul_press_total", press_cnt[0] + press_cnt[1], 2);
    clr();
    hold(1'b1, 2'b10, 8);
    check("simul_rel_10", rel_10, 1);
    check("simul_rel0", rel_cnt[0], 0);
    check("simul_out_after", int'(btn_out), 1);
    hold(1'b1, 2'b11, 10);

    // Reset two cycles into WAIT_P, button held across release.
    clr();
    hold(1'b1, 2'b10, 4);
    hold(1'b0, 2'b10, 3);
    check("rst_mid_press_during", press_cnt[0], 0);
    check("rst_mid_out_during", int'(btn_out), 0);
    t_mark = cyc_n + 1;
    hold(1'b1, 2'b10, 8);
    check("rst_mid_press_after", press_cnt[0], 1);
    check("rst_mid_latency", first_press[0] - t_mark, 5);
    hold(1'b1, 2'b11, 10);

    // Randomised segments, including occasional resets, checked every cycle by the model.
    done = 0;
    while (done < 3000) begin
      int         len;
      logic [1:0] raw;
      logic       rst;
      len  = int'($urandom_range(1, 8));
      raw  = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 59) != 0);
      hold(rst, raw, len);
      done += len;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
